// File: rtl/f_fetch_unit.sv
// f_fetch_unit: fetch-stage PC register plus F/D pipeline register.
// Issues one instruction-memory request at a time over req/gnt/rvalid and
// hands {D_PC, D_instr} to decode, holding the response in a local buffer
// while decode is stalled.
// Optional feature macro: F_ADDR_CHK_EN (misaligned fetch address raises
// D_exc, injects a nop into D and parks the unit in HALT until reset).
module f_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [31:0] D_NPC,
   input  logic        D_stall,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] F_PC,
   output logic [31:0] D_PC,
   output logic [31:0] D_instr,
   output logic        D_valid,
   output logic        D_fire,
   output logic        D_exc
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
`ifdef F_ADDR_CHK_EN
      S_HALT,
`endif
      S_HOLD
   } state_t;

   // Decode-side register contents travel together on every load.
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } d_reg_t;

   state_t      state;
   logic [31:0] hold_q;     // response captured while decode was stalled
   logic        fire;       // normal D load this edge
   logic [31:0] fire_instr; // instruction word loaded on a normal fire
   logic        npc_ok;     // next PC may be requested from memory
   logic        rst_ok;     // reset PC may be requested from memory
   d_reg_t      d_next;

   // Address gating: with the check enabled a misaligned PC never reaches
   // memory; otherwise the low two bits are simply dropped.
`ifdef F_ADDR_CHK_EN
   logic        exc_fire;   // misaligned PC in REQ, injecting a nop
   assign npc_ok    = (D_NPC[1:0] == 2'b00);
   assign rst_ok    = (RESET_PC[1:0] == 2'b00);
   assign imem_addr = F_PC;
`else
   assign npc_ok    = 1'b1;
   assign rst_ok    = 1'b1;
   assign imem_addr = {F_PC[31:2], 2'b00};
   assign D_exc     = 1'b0;
`endif

   // Decide whether decode is loaded this edge and with which word.
   always_comb begin
      fire       = 1'b0;
      fire_instr = imem_rdata;
      case (state)
         S_WAIT: fire = imem_rvalid && !D_stall;
         S_HOLD: begin
            fire       = !D_stall;
            fire_instr = hold_q;
         end
         default: ;
      endcase
   end

`ifdef F_ADDR_CHK_EN
   // A misaligned PC sitting in REQ fires a nop once decode can take it.
   always_comb begin
      exc_fire = (state == S_REQ) && (F_PC[1:0] != 2'b00) && !D_stall;
   end
`endif

   assign d_next = '{pc: F_PC, instr: fire_instr};

   // Fetch FSM, PC register and F/D register with registered outputs.
`ifdef F_ADDR_CHK_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= S_IDLE;
         F_PC     <= RESET_PC;
         D_PC     <= 32'h0;
         D_instr  <= 32'h0;
         D_valid  <= 1'b0;
         D_fire   <= 1'b0;
         D_exc    <= 1'b0;
         imem_req <= 1'b0;
         hold_q   <= 32'h0;
      end else begin
         D_fire <= 1'b0;
         case (state)
            S_IDLE: begin
               state    <= S_REQ;
               imem_req <= rst_ok;
            end
            S_REQ: begin
               // A stall never blocks issue, only the load into decode.
               if (exc_fire) begin
                  D_PC    <= F_PC;
                  D_instr <= 32'h0;
                  D_valid <= 1'b1;
                  D_fire  <= 1'b1;
                  D_exc   <= 1'b1;
                  state   <= S_HALT;
               end else if (imem_gnt && F_PC[1:0] == 2'b00) begin
                  imem_req <= 1'b0;
                  state    <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (imem_rvalid && D_stall) begin
                  hold_q <= imem_rdata;
                  state  <= S_HOLD;
               end
            end
            S_HOLD: ;
            S_HALT: ;
            default: state <= S_IDLE;
         endcase
         if (fire) begin
            D_PC     <= d_next.pc;
            D_instr  <= d_next.instr;
            D_valid  <= 1'b1;
            D_fire   <= 1'b1;
            F_PC     <= D_NPC;
            imem_req <= npc_ok;
            state    <= S_REQ;
         end
      end
   end
`else
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= S_IDLE;
         F_PC     <= RESET_PC;
         D_PC     <= 32'h0;
         D_instr  <= 32'h0;
         D_valid  <= 1'b0;
         D_fire   <= 1'b0;
         imem_req <= 1'b0;
         hold_q   <= 32'h0;
      end else begin
         D_fire <= 1'b0;
         case (state)
            S_IDLE: begin
               state    <= S_REQ;
               imem_req <= rst_ok;
            end
            S_REQ: begin
               // A stall never blocks issue, only the load into decode.
               if (imem_gnt) begin
                  imem_req <= 1'b0;
                  state    <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (imem_rvalid && D_stall) begin
                  hold_q <= imem_rdata;
                  state  <= S_HOLD;
               end
            end
            S_HOLD: ;
            default: state <= S_IDLE;
         endcase
         if (fire) begin
            D_PC     <= d_next.pc;
            D_instr  <= d_next.instr;
            D_valid  <= 1'b1;
            D_fire   <= 1'b1;
            F_PC     <= D_NPC;
            imem_req <= npc_ok;
            state    <= S_REQ;
         end
      end
   end
`endif

endmodule

// File: tb/tb_f_fetch_unit.sv
// Directed bench for f_fetch_unit: memory handshake driven step by step,
// expected values hand-computed from the intended behaviour.
module tb_f_fetch_unit;
   logic        clk = 1'b0;
   logic        reset_n;
   logic [31:0] D_NPC;
   logic        D_stall;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic [31:0] F_PC, D_PC, D_instr;
   logic        D_valid, D_fire, D_exc;

   int tests = 0;
   int fails = 0;
   int hs_cnt = 0;

   f_fetch_unit dut (
      .clk(clk), .reset_n(reset_n), .D_NPC(D_NPC), .D_stall(D_stall),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .F_PC(F_PC),
      .D_PC(D_PC), .D_instr(D_instr), .D_valid(D_valid), .D_fire(D_fire),
      .D_exc(D_exc)
   );

   always #5 clk = ~clk;

   // Accepted requests (req && gnt at a rising edge).
   always @(posedge clk) if (reset_n && imem_req && imem_gnt) hs_cnt <= hs_cnt + 1;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   initial begin
      reset_n = 1'b0; D_NPC = 32'h0; D_stall = 1'b0;
      imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
      #12;
      chk32("rst_fpc", F_PC, 32'h0000_3000);
      chk32("rst_dpc", D_PC, 32'h0);
      chk32("rst_dinstr", D_instr, 32'h0);
      chk1("rst_dvalid", D_valid, 1'b0);
      chk1("rst_dfire", D_fire, 1'b0);
      chk1("rst_dexc", D_exc, 1'b0);
      chk1("rst_req", imem_req, 1'b0);
      reset_n = 1'b1;

      // 1: back-to-back fetch, 2 cycles per instruction
      tick();
      chk1("t1_req0", imem_req, 1'b1);
      chk32("t1_addr0", imem_addr, 32'h3000);
      imem_gnt = 1'b1; D_NPC = 32'h3004;
      tick();
      chk1("t1_wait_req", imem_req, 1'b0);
      imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hA000_0000;
      tick();
      chk1("t1_fire0", D_fire, 1'b1);
      chk32("t1_dpc0", D_PC, 32'h3000);
      chk32("t1_dinstr0", D_instr, 32'hA000_0000);
      chk1("t1_dvalid", D_valid, 1'b1);
      chk32("t1_addr1", imem_addr, 32'h3004);
      chk1("t1_req1", imem_req, 1'b1);
      imem_rvalid = 1'b0; imem_gnt = 1'b1; D_NPC = 32'h3008;
      tick();
      chk1("t1_nofire", D_fire, 1'b0);
      imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hA000_0001;
      tick();
      chk1("t1_fire1", D_fire, 1'b1);
      chk32("t1_dpc1", D_PC, 32'h3004);
      chk32("t1_addr2", imem_addr, 32'h3008);

      // 2: response arrives under stall, held three cycles
      imem_rvalid = 1'b0; imem_gnt = 1'b1; D_NPC = 32'h300C;
      tick();
      imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h1234_5678; D_stall = 1'b1;
      tick();
      imem_rvalid = 1'b0;
      chk32("t2_hold_instr", D_instr, 32'hA000_0001);
      chk1("t2_hold_fire", D_fire, 1'b0);
      chk1("t2_hold_req", imem_req, 1'b0);
      tick();
      chk32("t2_hold_instr2", D_instr, 32'hA000_0001);
      tick();
      chk1("t2_hold_req3", imem_req, 1'b0);
      // 3: redirect taken at this fire
      D_stall = 1'b0; D_NPC = 32'h0000_3100;
      tick();
      chk32("t2_rel_instr", D_instr, 32'h1234_5678);
      chk1("t2_rel_fire", D_fire, 1'b1);
      chk32("t3_dpc", D_PC, 32'h3008);
      chk32("t3_addr", imem_addr, 32'h3100);
      chk1("t2_req", imem_req, 1'b1);

      // 4: grant delayed 3 cycles, request stable
      D_NPC = 32'hDEAD_BEEC;   // ignored until next fire
      for (int i = 0; i < 3; i++) begin
         tick();
         chk1("t4_req_stable", imem_req, 1'b1);
         chk32("t4_addr_stable", imem_addr, 32'h3100);
      end
      imem_gnt = 1'b1;
      tick();
      chk1("t4_wait_req", imem_req, 1'b0);
      chk32("t4_hs_count", 32'(hs_cnt), 32'd4);
      imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hB000_0000; D_NPC = 32'h3104;
      tick();
      chk32("t4_dpc", D_PC, 32'h3100);
      chk32("t4_addr_next", imem_addr, 32'h3104);
      // stray rvalid in REQ is ignored
      tick();
      chk1("stray_req", imem_req, 1'b1);
      chk1("stray_fire", D_fire, 1'b0);
      chk32("stray_instr", D_instr, 32'hB000_0000);
      imem_rvalid = 1'b0; imem_gnt = 1'b1;
      tick();
      imem_gnt = 1'b0;

      // 5: asynchronous reset during WAIT
      #2 reset_n = 1'b0;
      #1;
      chk32("t5_fpc", F_PC, 32'h3000);
      chk32("t5_dpc", D_PC, 32'h0);
      chk32("t5_dinstr", D_instr, 32'h0);
      chk1("t5_dvalid", D_valid, 1'b0);
      chk1("t5_req", imem_req, 1'b0);
      @(negedge clk);
      reset_n = 1'b1;
      tick();
      chk1("t5_req_after", imem_req, 1'b1);
      chk32("t5_addr_after", imem_addr, 32'h3000);

      // 6: misaligned next PC
      imem_gnt = 1'b1; D_NPC = 32'h3002;
      tick();
      imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hC000_0000;
      tick();
      imem_rvalid = 1'b0;
      chk32("t6_fpc", F_PC, 32'h3002);
`ifdef F_ADDR_CHK_EN
      chk1("t6_noreq", imem_req, 1'b0);
      imem_gnt = 1'b1;
      tick();
      chk1("t6_exc", D_exc, 1'b1);
      chk32("t6_dinstr", D_instr, 32'h0);
      chk32("t6_dpc", D_PC, 32'h3002);
      chk1("t6_fire", D_fire, 1'b1);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk1("t6_halt_req", imem_req, 1'b0);
         chk1("t6_halt_fire", D_fire, 1'b0);
         chk1("t6_halt_exc", D_exc, 1'b1);
      end
      imem_gnt = 1'b0;
`else
      chk1("t6_req", imem_req, 1'b1);
      chk32("t6_addr", imem_addr, 32'h3000);
      chk1("t6_exc", D_exc, 1'b0);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   // Global time bound so the run always terminates.
   initial begin
      #100000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end
endmodule
